// File: rtl/tstamp_capture_fifo.sv
// Multi-channel hit time-stamper: per-channel edge capture, fixed-priority arbitration
// into a show-ahead FIFO, plus sticky overflow flag and saturating drop counter.
module tstamp_capture_fifo #(
    parameter int TS_WIDTH  = 16,
    parameter int N_CH      = 4,
    parameter int CH_ID_W   = 2,
    parameter int LOG_DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic [N_CH-1:0]             hit_i,
    input  logic [N_CH-1:0]             ch_mask_i,
    input  logic                        clr_ovf_i,
    output logic [TS_WIDTH-1:0]         tstamp_o,
    output logic [CH_ID_W+TS_WIDTH-1:0] rd_data_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [LOG_DEPTH:0]          level_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        ovf_o,
    output logic [7:0]                  drop_cnt_o
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int DW    = CH_ID_W + TS_WIDTH;
    localparam int CNT_W = $clog2(N_CH + 1);

    logic [TS_WIDTH-1:0]  ts_r;
    logic [N_CH-1:0]      hit_q_r;
    logic [N_CH-1:0]      pending_r;
    logic [TS_WIDTH-1:0]  hold_r [N_CH];
    logic [DW-1:0]        mem_r [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_r;
    logic [LOG_DEPTH-1:0] rd_ptr_r;
    logic [LOG_DEPTH:0]   level_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 ovf_r;
    logic [7:0]           drop_cnt_r;

    logic [N_CH-1:0]      edge_s;
    logic [N_CH-1:0]      grant_s;
    logic [N_CH-1:0]      drain_s;
    logic [N_CH-1:0]      drop_s;
    logic [N_CH-1:0]      accept_s;
    logic [CH_ID_W-1:0]   win_id_s;
    logic [TS_WIDTH-1:0]  win_ts_s;
    logic [CNT_W-1:0]     drop_num_s;
    logic                 push_s;
    logic                 pop_s;
    logic [LOG_DEPTH:0]   level_nx_s;
    logic                 ovf_nx_s;
    logic [7:0]           drop_cnt_nx_s;

    // Clamp a 9-bit count to the 8-bit statistics range.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    assign tstamp_o   = ts_r;
    assign rd_data_o  = mem_r[rd_ptr_r];
    assign rd_valid_o = ~empty_r;
    assign empty_o    = empty_r;
    assign full_o     = full_r;
    assign level_o    = level_r;
    assign ovf_o      = ovf_r;
    assign drop_cnt_o = drop_cnt_r;

    // Handshake, edge detection and lowest-index-wins grant (isolate lowest set bit).
    always_comb begin
        edge_s  = hit_i & ~hit_q_r & ch_mask_i & {N_CH{en_i}};
        pop_s   = ~empty_r & rd_ready_i;
        push_s  = (|pending_r) & (~full_r | pop_s);
        grant_s = pending_r & (~pending_r + N_CH'(1));
        drain_s = grant_s & {N_CH{push_s}};
        // A channel being drained this cycle frees its slot for a simultaneous edge.
        drop_s   = edge_s & pending_r & ~drain_s;
        accept_s = edge_s & ~drop_s;
    end

    // Winner id/timestamp mux and per-cycle drop population count.
    always_comb begin
        win_id_s   = '0;
        win_ts_s   = '0;
        drop_num_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            win_id_s   = win_id_s | (grant_s[k] ? CH_ID_W'(k) : CH_ID_W'(0));
            win_ts_s   = win_ts_s | ({TS_WIDTH{grant_s[k]}} & hold_r[k]);
            drop_num_s = drop_num_s + CNT_W'(drop_s[k]);
        end
    end

    // Next FIFO occupancy.
    always_comb begin
        level_nx_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nx_s = level_r + (LOG_DEPTH+1)'(1);
            2'b01:   level_nx_s = level_r - (LOG_DEPTH+1)'(1);
            default: level_nx_s = level_r;
        endcase
    end

    // Next statistics; a drop in the clearing cycle wins over the clear.
    always_comb begin
        ovf_nx_s      = ovf_r;
        drop_cnt_nx_s = drop_cnt_r;
        if (clr_ovf_i) begin
            ovf_nx_s      = |drop_s;
            drop_cnt_nx_s = sat8(9'(drop_num_s));
        end else begin
            ovf_nx_s      = ovf_r | (|drop_s);
            drop_cnt_nx_s = sat8({1'b0, drop_cnt_r} + 9'(drop_num_s));
        end
    end

    // Free-running timestamp and edge-detect history (history ones so held hits are ignored).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r    <= '0;
            hit_q_r <= '1;
        end else begin
            hit_q_r <= hit_i;
            if (en_i) begin
                ts_r <= ts_r + TS_WIDTH'(1);
            end
        end
    end

    // Per-channel holding registers and pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                hold_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (accept_s[k]) begin
                    hold_r[k]    <= ts_r;
                    pending_r[k] <= 1'b1;
                end else if (drain_s[k]) begin
                    pending_r[k] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage, pointers and occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {win_id_s, win_ts_s};
                wr_ptr_r        <= wr_ptr_r + LOG_DEPTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LOG_DEPTH'(1);
            end
            level_r <= level_nx_s;
            full_r  <= (level_nx_s == (LOG_DEPTH+1)'(DEPTH));
            empty_r <= (level_nx_s == (LOG_DEPTH+1)'(0));
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r      <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            ovf_r      <= ovf_nx_s;
            drop_cnt_r <= drop_cnt_nx_s;
        end
    end

endmodule

// File: tb/tb_tstamp_capture_fifo.sv
// Scenario bench for tstamp_capture_fifo: expected FIFO words are queued when hits are
// driven and compared by a read monitor whenever a pop occurs.
module tb_tstamp_capture_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b1;
    logic [3:0]  hit_i = 4'd0;
    logic [3:0]  ch_mask_i = 4'hF;
    logic        clr_ovf_i = 1'b0;
    logic        rd_ready_i = 1'b0;
    logic [15:0] tstamp_o;
    logic [17:0] rd_data_o;
    logic        rd_valid_o;
    logic [3:0]  level_o;
    logic        full_o;
    logic        empty_o;
    logic        ovf_o;
    logic [7:0]  drop_cnt_o;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] tb_ts = 16'd0;
    logic [17:0] exp_q[$];

    tstamp_capture_fifo #(.TS_WIDTH(16), .N_CH(4), .CH_ID_W(2), .LOG_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .hit_i(hit_i), .ch_mask_i(ch_mask_i),
        .clr_ovf_i(clr_ovf_i), .tstamp_o(tstamp_o), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .level_o(level_o),
        .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Read monitor: a pop happens at the next rising edge, so compare the head now.
    always @(negedge clk) begin : mon
        logic [17:0] e;
        if (!rst && rd_valid_o && rd_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%h exp=none", rd_data_o);
            end else begin
                e = exp_q.pop_front();
                if (rd_data_o !== e) begin
                    failures++;
                    $display("FAIL pop_data got=%h exp=%h", rd_data_o, e);
                end
            end
        end
    end

    function automatic logic [17:0] ent(input int ch, input logic [15:0] ts);
        return {2'(ch), ts};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst && en_i) tb_ts = tb_ts + 16'd1;
        #1;
    endtask

    task automatic wait_ts(input logic [15:0] t, input int budget);
        int n = 0;
        while (tb_ts != t && n < budget) begin tick(); n++; end
        checks++;
        if (tstamp_o !== t) begin failures++; $display("FAIL wait_ts got=%h exp=%h", tstamp_o, t); end
    endtask

    task automatic drain();
        int n = 0;
        rd_ready_i = 1'b1;
        while ((exp_q.size() != 0 || rd_valid_o) && n < 100) begin tick(); n++; end
        rd_ready_i = 1'b0;
        checks++;
        if (exp_q.size() != 0 || rd_valid_o !== 1'b0 || level_o !== 4'd0 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL drain left=%0d valid=%b level=%0d exp left=0 valid=0 level=0", exp_q.size(), rd_valid_o, level_o);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tb_ts = 16'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic fill_ch0(input int n);
        for (int i = 0; i < n; i++) begin
            hit_i = 4'b0001; exp_q.push_back(ent(0, tb_ts)); tick();
            hit_i = 4'b0000; tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (level_o !== 4'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || rd_valid_o !== 1'b0 ||
            ovf_o !== 1'b0 || drop_cnt_o !== 8'd0 || tstamp_o !== 16'd0 || rd_data_o !== 18'd0) begin
            failures++;
            $display("FAIL reset_state got lvl=%0d e=%b f=%b v=%b ovf=%b cnt=%0d ts=%h d=%h exp all zero, empty=1",
                     level_o, empty_o, full_o, rd_valid_o, ovf_o, drop_cnt_o, tstamp_o, rd_data_o);
        end
        do_reset();
    endtask

    task automatic test_single_hit();
        wait_ts(16'h0005, 20);
        hit_i = 4'b0100; exp_q.push_back(ent(2, 16'h0005)); tick();
        hit_i = 4'b0000;
        checks++;
        if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", rd_valid_o); end
        tick();
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 18'h20005 || level_o !== 4'd1) begin
            failures++;
            $display("FAIL single_hit got v=%b d=%h l=%0d exp v=1 d=20005 l=1", rd_valid_o, rd_data_o, level_o);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        wait_ts(16'h0010, 40);
        hit_i = 4'b1011;
        exp_q.push_back(ent(0, 16'h0010)); exp_q.push_back(ent(1, 16'h0010)); exp_q.push_back(ent(3, 16'h0010));
        tick();
        hit_i = 4'b0000;
        tick(); tick(); tick();
        checks++;
        if (level_o !== 4'd3 || rd_data_o !== 18'h00010) begin
            failures++;
            $display("FAIL simultaneous got l=%0d d=%h exp l=3 d=00010", level_o, rd_data_o);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) begin
            hit_i = 4'b0010;
            if (i < 9) exp_q.push_back(ent(1, tb_ts));
            tick();
            hit_i = 4'b0000; tick();
        end
        checks++;
        if (full_o !== 1'b1 || level_o !== 4'd8 || ovf_o !== 1'b1 || drop_cnt_o !== 8'd3) begin
            failures++;
            $display("FAIL overflow got f=%b l=%0d ovf=%b cnt=%0d exp f=1 l=8 ovf=1 cnt=3", full_o, level_o, ovf_o, drop_cnt_o);
        end
        drain();
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
        checks++;
        if (ovf_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL clear got ovf=%b cnt=%0d exp ovf=0 cnt=0", ovf_o, drop_cnt_o);
        end
    endtask

    task automatic test_push_pop_full();
        fill_ch0(8);
        hit_i = 4'b0001; exp_q.push_back(ent(0, tb_ts)); tick();
        hit_i = 4'b0000;
        checks++;
        if (level_o !== 4'd8 || full_o !== 1'b1) begin failures++; $display("FAIL full_wait got l=%0d f=%b exp l=8 f=1", level_o, full_o); end
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        checks++;
        if (level_o !== 4'd8 || full_o !== 1'b1 || drop_cnt_o !== 8'd0 || ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_full got l=%0d f=%b cnt=%0d exp l=8 f=1 cnt=0", level_o, full_o, drop_cnt_o);
        end
        drain();
    endtask

    task automatic test_wrap_and_reset();
        wait_ts(16'hFFFF, 70000);
        hit_i = 4'b1000; exp_q.push_back(ent(3, 16'hFFFF)); tick();
        hit_i = 4'b0000;
        checks++;
        if (tstamp_o !== 16'h0000) begin failures++; $display("FAIL wrap got=%h exp=0000", tstamp_o); end
        tick();
        hit_i = 4'b1000; exp_q.push_back(ent(3, 16'h0001)); tick();
        hit_i = 4'b0000; tick(); tick();
        checks++;
        if (level_o !== 4'd2) begin failures++; $display("FAIL wrap_level got=%0d exp=2", level_o); end
        drain();
        hit_i = 4'b0001; tick(); tick();
        rst = 1'b1; #1;
        checks++;
        if (level_o !== 4'd0 || rd_valid_o !== 1'b0 || tstamp_o !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got l=%0d v=%b ts=%h exp l=0 v=0 ts=0000", level_o, rd_valid_o, tstamp_o);
        end
        exp_q.delete(); tb_ts = 16'd0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (level_o !== 4'd0 || rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL held_hit got l=%0d v=%b exp l=0 v=0", level_o, rd_valid_o);
        end
        hit_i = 4'b0000; tick();
    endtask

    task automatic test_drops_and_enable();
        logic [15:0] frozen;
        fill_ch0(8);
        hit_i = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(ent(k, tb_ts));
        tick();
        hit_i = 4'b0000; tick();
        for (int i = 0; i < 75; i++) begin
            hit_i = 4'b1111; tick();
            hit_i = 4'b0000; tick();
            if (i == 9) begin
                checks++;
                if (drop_cnt_o !== 8'd40) begin failures++; $display("FAIL multi_drop got=%0d exp=40", drop_cnt_o); end
            end
        end
        checks++;
        if (drop_cnt_o !== 8'd255 || ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL saturate got cnt=%0d ovf=%b exp cnt=255 ovf=1", drop_cnt_o, ovf_o);
        end
        hit_i = 4'b0010; clr_ovf_i = 1'b1; tick();
        hit_i = 4'b0000; clr_ovf_i = 1'b0;
        checks++;
        if (drop_cnt_o !== 8'd1 || ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_drop got cnt=%0d ovf=%b exp cnt=1 ovf=1", drop_cnt_o, ovf_o);
        end
        drain();
        ch_mask_i = 4'b1110;
        hit_i = 4'b0101; exp_q.push_back(ent(2, tb_ts)); tick();
        hit_i = 4'b0000; en_i = 1'b0; tick();
        checks++;
        if (level_o !== 4'd1) begin failures++; $display("FAIL drain_disabled got l=%0d exp l=1", level_o); end
        drain();
        ch_mask_i = 4'hF;
        frozen = tb_ts;
        for (int i = 0; i < 5; i++) begin
            hit_i = 4'b1111; tick();
            hit_i = 4'b0000; tick();
        end
        checks++;
        if (tstamp_o !== frozen || level_o !== 4'd0 || rd_valid_o !== 1'b0 || drop_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL disabled got ts=%h l=%0d v=%b cnt=%0d exp ts=%h l=0 v=0 cnt=1",
                     tstamp_o, level_o, rd_valid_o, drop_cnt_o, frozen);
        end
        en_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_overflow();
        test_push_pop_full();
        test_wrap_and_reset();
        test_drops_and_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
